// File: rtl/axil_cfg_responder.sv
// AXI4-Lite CSR responder: ID, IER, W1C ISR and scratch registers with interrupt output.
// Define AXIL_SLVERR_EN to return SLVERR for out-of-range accesses.
module axil_cfg_responder #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 16,
  parameter int          IRQ_WIDTH  = 8,
  parameter logic [31:0] ID_VALUE   = 32'hCAFE0001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [IRQ_WIDTH-1:0]    irq_evt,
  output logic                    interrupt
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_REGS);
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] NREG = WW'(NUM_REGS);
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic                  aw_full;
  logic                  w_full;
  logic [WW-1:0]         aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]         w_strb;
  logic [IRQ_WIDTH-1:0]  ier;
  logic [IRQ_WIDTH-1:0]  isr;
  logic [DATA_WIDTH-1:0] scratch [NUM_REGS];

  logic                  wfire;
  logic                  w_hit;
  logic [IW-1:0]         wr_sel;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] wdm;
  logic [IRQ_WIDTH-1:0]  isr_clr;
  logic [WW-1:0]         ar_idx;
  logic [IW-1:0]         ar_sel;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [1:0]            rd_resp;
  logic                  unused_bits;

  assign unused_bits = ^{awaddr[1:0], araddr[1:0]};

  assign awready = !aw_full;
  assign wready  = !w_full;
  assign arready = !rvalid;

  assign wfire  = aw_full && w_full && (!bvalid || bready);
  assign w_hit  = aw_idx < NREG;
  assign wr_sel = aw_idx[IW-1:0];
  assign wdm    = w_data & wmask;

  assign ar_idx = araddr[ADDR_WIDTH-1:2];
  assign ar_sel = ar_idx[IW-1:0];

  // Flop-only source keeps the interrupt free of bus-input paths
  assign interrupt = |(ier & isr);

  always_comb begin
    wmask = '0;
    for (int i = 0; i < SW; i++) begin
      wmask[i*8 +: 8] = {8{w_strb[i]}};
    end
  end

  always_comb begin
    isr_clr = '0;
    if (wfire && w_hit && wr_sel == IW'(2)) begin
      isr_clr = wdm[IRQ_WIDTH-1:0];
    end
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = 2'b00;
    if (ar_idx >= NREG) begin
      rd_resp = ERR;
    end else begin
      unique case (ar_sel)
        IW'(0):  rd_val = DATA_WIDTH'(ID_VALUE);
        IW'(1):  rd_val = DATA_WIDTH'(ier);
        IW'(2):  rd_val = DATA_WIDTH'(isr);
        default: rd_val = scratch[ar_sel];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
    end else begin
      if (awvalid && awready) begin
        aw_full <= 1'b1;
        aw_idx  <= awaddr[ADDR_WIDTH-1:2];
      end else if (wfire) begin
        aw_full <= 1'b0;
      end
      if (wvalid && wready) begin
        w_full <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end else if (wfire) begin
        w_full <= 1'b0;
      end
      if (wfire) begin
        bvalid <= 1'b1;
        bresp  <= w_hit ? 2'b00 : ERR;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ier <= '0;
      isr <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        scratch[i] <= '0;
      end
    end else begin
      if (wfire && w_hit && wr_sel == IW'(1)) begin
        ier <= (ier & ~wmask[IRQ_WIDTH-1:0]) | wdm[IRQ_WIDTH-1:0];
      end
      if (wfire && w_hit && wr_sel >= IW'(3)) begin
        scratch[wr_sel] <= (scratch[wr_sel] & ~wmask) | wdm;
      end
      // New events override a same-edge W1C clear
      isr <= (isr & ~isr_clr) | irq_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_val;
      rresp  <= rd_resp;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule
